// File: rtl/cache_flush_sm.sv
// Initialise/flush sequencer for the cache valid/state matrix. Sweeps all sets after reset,
// then services flush requests over a set range and way mask, one set per cycle.
module cache_flush_sm #(
    parameter int unsigned                  SET_AMOUNT   = 64,
    parameter int unsigned                  SET_BITS     = $clog2(SET_AMOUNT),
    parameter int unsigned                  WAYS         = 4,
    parameter int unsigned                  MATRIX_WIDTH = 8,
    parameter logic [MATRIX_WIDTH-1:0]      INIT_VALUE   = '1
) (
    input  logic                    clk_i,
    input  logic                    rstn_i,
    input  logic                    flush_req_i,
    input  logic                    flush_all_i,
    input  logic [SET_BITS-1:0]     flush_first_i,
    input  logic [SET_BITS-1:0]     flush_last_i,
    input  logic [WAYS-1:0]         flush_way_i,
    output logic                    flush_gnt_o,
    output logic                    ready_o,
    output logic                    done_o,
    output logic                    err_o,
    output logic                    sel_o,
    output logic                    we_o,
    output logic [WAYS-1:0]         way_we_o,
    output logic [SET_BITS-1:0]     addr_o,
    output logic [MATRIX_WIDTH-1:0] vect_o
);

    localparam logic [SET_BITS:0]   SetAmt = (SET_BITS + 1)'(SET_AMOUNT);
    localparam logic [SET_BITS-1:0] SetMax = SET_BITS'(SET_AMOUNT - 1);

    typedef enum logic [1:0] {StInit, StIdle, StSweep} state_e;

    state_e              state_q, state_d;
    logic [SET_BITS-1:0] cnt_q, cnt_d;
    logic [SET_BITS-1:0] last_q, last_d;
    logic [WAYS-1:0]     way_q, way_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    logic [SET_BITS-1:0] req_first;
    logic [SET_BITS-1:0] req_last;
    logic                req_valid;

    // Effective range of the incoming request; bounds are checked against SET_AMOUNT
    // so non-power-of-two set counts reject addresses past the last real set.
    always_comb begin
        req_first = flush_all_i ? '0 : flush_first_i;
        req_last  = flush_all_i ? SetMax : flush_last_i;
        req_valid = (req_first <= req_last)
                  && ({1'b0, req_first} < SetAmt)
                  && ({1'b0, req_last} < SetAmt)
                  && (|flush_way_i);
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q <= StInit;
            cnt_q   <= '0;
            last_q  <= '0;
            way_q   <= '1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            way_q   <= way_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        way_d   = way_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            StInit: begin
                if (cnt_q == SetMax) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + SET_BITS'(1);
                end
            end
            StIdle: begin
                if (flush_req_i) begin
                    last_d = req_last;
                    way_d  = flush_way_i;
                    if (req_valid) begin
                        state_d = StSweep;
                        cnt_d   = req_first;
                    end else begin
                        done_d = 1'b1;
                        err_d  = 1'b1;
                    end
                end
            end
            StSweep: begin
                // Equality stop keeps the counter from ever wrapping past the last set.
                if (cnt_q == last_q) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + SET_BITS'(1);
                end
            end
            default: begin
                state_d = StInit;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        ready_o     = (state_q == StIdle);
        flush_gnt_o = (state_q == StIdle) && flush_req_i;
        we_o        = (state_q != StIdle);
        sel_o       = we_o;
        way_we_o    = we_o ? way_q : '0;
        addr_o      = cnt_q;
        vect_o      = INIT_VALUE;
        done_o      = done_q;
        err_o       = err_q;
    end

endmodule

// File: doc/cache_flush_sm.md
# cache_flush_sm

Parametrised initialise/flush sequencer for the cache valid/state matrix.
- After reset it sweeps every set and writes `INIT_VALUE` into all ways.
- Afterwards it accepts flush requests covering a set range and a way mask, and performs the same sweep restricted to those sets and ways.
- It sits beside the cache controller and drives the matrix write port (`sel_o`/`we_o`/`addr_o`/`vect_o`) whenever it owns the memory.
- `ready_o` tells the controller when normal lookups may proceed.

## Interface
Parameters:
- `SET_AMOUNT`, 64 — number of sets; need not be a power of two.
- `SET_BITS`, `$clog2(SET_AMOUNT)` — set address width.
- `WAYS`, 4 — number of ways; one write-enable bit per way.
- `MATRIX_WIDTH`, 8 — width of the per-way vector written into the matrix.
- `INIT_VALUE`, `'1` — vector written on every sweep write.

Ports (one clock; reset is synchronous and active-low):
- `clk_i`  in  1  clock; all state changes on the rising edge.
- `rstn_i`  in  1  synchronous active-low reset.
- `flush_req_i`  in  1  flush request; held until granted.
- `flush_all_i`  in  1  flush all sets and ignore the range inputs.
- `flush_first_i`  in  `SET_BITS`  first set of the range.
- `flush_last_i`  in  `SET_BITS`  last set of the range, inclusive.
- `flush_way_i`  in  `WAYS`  ways to flush.
- `flush_gnt_o`  out  1  request accepted this cycle.
- `ready_o`  out  1  idle and initialised; controller may use the matrix.
- `done_o`  out  1  one-cycle pulse when a sweep (init or flush) completes.
- `err_o`  out  1  one-cycle pulse with `done_o` when a flush was rejected as empty or invalid.
- `sel_o`  out  1  sequencer owns the matrix port.
- `we_o`  out  1  write strobe.
- `way_we_o`  out  `WAYS`  per-way write enable.
- `addr_o`  out  `SET_BITS`  set address.
- `vect_o`  out  `MATRIX_WIDTH`  write data; constant `INIT_VALUE`.

## Operation
- States: `INIT`, `IDLE`, `SWEEP`.
- Reset state is `INIT`, with address counter 0 and way mask all ones.
- **`INIT`**
  - Writes address 0 up to `SET_AMOUNT-1`, one set per cycle, with all ways enabled.
  - Goes to `IDLE` after writing `SET_AMOUNT-1`.
- **`IDLE`**
  - `flush_gnt_o = flush_req_i`, combinationally.
  - On a grant edge the block latches `first`, `last` and `way`. If `flush_all_i`=1, `first`=0 and `last`=`SET_AMOUNT-1`.
  - If the request is valid it moves to `SWEEP` with the counter at `first`.
  - A request is invalid if `first`>`last`, if either bound is ≥`SET_AMOUNT`, or if the way mask is 0.
  - An invalid request stays in `IDLE` and pulses `done_o` and `err_o` in the next cycle; no writes are issued.
- **`SWEEP`**
  - Writes sets `first` to `last` inclusive with `way_we_o`=latched mask.
  - After the write at `last` it returns to `IDLE`.
  - Length is exactly `last-first+1` cycles.
  - The counter stops by equality compare and never wraps past `SET_AMOUNT-1`.
- Requests seen outside `IDLE` are not granted. `flush_gnt_o`=0 and the requester keeps `flush_req_i` high.
- The output decode is:
  - `sel_o` = `we_o` = (state≠`IDLE`).
  - `way_we_o` = the active mask when `we_o`=1, otherwise 0.
  - `addr_o` = counter.
  - `ready_o` = (state==`IDLE`).
- `done_o` and `err_o` are registered pulses.
- Reset asserted in any state, including mid-sweep, aborts the operation. A full `INIT` sweep follows reset release; the partial flush is not resumed.

## Timing
- While `rstn_i`=0 the state is `INIT` and the counter is 0. The outputs are:
  - `ready_o`=0, `done_o`=0, `err_o`=0, `flush_gnt_o`=0.
  - `sel_o`/`we_o`=1 and `way_we_o`=all ones, because reset state is `INIT`.
  - The matrix ignores writes while held in reset.
- Cycle 0 is the first cycle with `rstn_i`=1. Init writes occupy cycles 0 to `SET_AMOUNT-1`, with `addr_o`=cycle number.
- Cycle `SET_AMOUNT`: `ready_o`=1 and `done_o`=1 for one cycle.
- Flush grant in cycle g:
  - Writes occupy cycles g+1 to g+1+(`last`-`first`).
  - In the following cycle `ready_o`=1 and `done_o`=1.
  - Earliest next grant is that same cycle.
- Rejected flush granted in cycle g: `done_o`=`err_o`=1 in cycle g+1, and `ready_o` stays 1 throughout.
- `flush_req_i` held continuously is granted once per completed sweep. There are no back-to-back grants without an intervening sweep, or the `done_o` cycle for rejects.

## Test plan
Bench parameters: `SET_AMOUNT`=64, `WAYS`=4, `MATRIX_WIDTH`=8, `INIT_VALUE`=8'hFF.
- **Reset release:** expect 64 writes with `addr_o` 0..63, `way_we_o`=4'hF and `vect_o`=8'hFF. `ready_o` and `done_o` rise in cycle 64, and `done_o` is high for exactly one cycle.
- **Range flush:** `first`=10, `last`=13, `way`=4'b0101, granted in cycle g. Expect writes to addresses 10, 11, 12, 13 in cycles g+1..g+4 with `way_we_o`=4'b0101, `done_o` in g+5 and `err_o`=0.
- **Boundary flush:** `flush_all_i`=1, `way`=4'b1000 writes 0..63 and stops without wrap. A separate `first`=`last`=63 flush writes once.
- **Invalid requests:** `first`=20, `last`=5 → no `we_o`, `done_o`=`err_o`=1 one cycle after grant. Way mask 0 and `last`=64-equivalent out-of-range give the same response.
- **Held request during init:** `flush_req_i` high from cycle 0 → no grant until cycle 64. The request is granted in cycle 64 and its sweep starts in cycle 65.
- **Reset mid-flush:** `rstn_i` low for 2 cycles during a flush of 0..63 at address 30. After release a full 0..63 init sweep runs, and no `done_o` is issued for the aborted flush.
